// File: rtl/spi_master_n.sv
// spi_master_n: parametrised full-duplex SPI master; define SPI_LSB_FIRST_EN for LSB-first bit order
module spi_master_n #(
  parameter int DATA_W = 64,
  parameter int NUM_CS = 1,
  parameter int CLK_DIV = 2,
  parameter int CPOL = 0,
  parameter int CPHA = 0,
  localparam int CSW = NUM_CS > 1 ? $clog2(NUM_CS) : 1
) (
  input  logic              sclk_m,
  input  logic              reset,
  input  logic              start,
  input  logic [CSW-1:0]    cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sck,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
  input  logic              miso,
  output logic [6:0]        bit_cnt
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [7:0] LAST = 8'(2 * DATA_W);
  localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, XFER = 3'd2, HOLD = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [7:0] edges;
  logic [DATA_W-1:0] tx_sr, rx_sr, tx_next, rx_next, load_next;
  logic [NUM_CS-1:0] cs_dec;
  logic tick, edge_go, sample, shift, tx_head, load_head;
  // Edge scheduling, chip-select decode and bit-order dependent shift paths
  always_comb begin
    tick = cnt == CW'(CLK_DIV - 1);
    edge_go = tick && (state == SETUP || (state == XFER && edges != LAST));
    sample = edge_go && (edges[0] == (CPHA != 0));
    shift = edge_go && !sample;
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) cs_dec[i] = cs_sel != CSW'(i);
`ifdef SPI_LSB_FIRST_EN
    tx_head = tx_sr[0];
    tx_next = tx_sr >> 1;
    load_head = tx_data[0];
    load_next = CPHA == 0 ? tx_data >> 1 : tx_data;
    rx_next = {miso, rx_sr[DATA_W-1:1]};
`else
    tx_head = tx_sr[DATA_W-1];
    tx_next = tx_sr << 1;
    load_head = tx_data[DATA_W-1];
    load_next = CPHA == 0 ? tx_data << 1 : tx_data;
    rx_next = {rx_sr[DATA_W-2:0], miso};
`endif
  end
  // Transfer sequencing: state, divider, SCK edges, shift registers and outputs
  always_ff @(posedge sclk_m or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      edges <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rx_data <= '0;
      sck <= 1'(CPOL);
      cs_n <= '1;
      mosi <= 1'b0;
      bit_cnt <= '0;
    end else begin
      cnt <= (state == IDLE || state == DONE || tick) ? '0 : cnt + CW'(1);
      case (state)
        IDLE: if (start) begin
          state <= SETUP;
          busy <= 1'b1;
          cs_n <= cs_dec;
          edges <= '0;
          bit_cnt <= '0;
          tx_sr <= load_next;
          if (CPHA == 0) mosi <= load_head;
        end
        SETUP: if (tick) state <= XFER;
        XFER: if (tick && edges == LAST) state <= HOLD;
        HOLD: if (tick) begin
          state <= DONE;
          done <= 1'b1;
          cs_n <= '1;
          rx_data <= rx_sr;
        end
        default: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
      if (edge_go) begin
        sck <= ~sck;
        edges <= edges + 8'd1;
      end
      if (sample) begin
        rx_sr <= rx_next;
        bit_cnt <= bit_cnt == 7'(DATA_W) ? bit_cnt : bit_cnt + 7'd1;
      end
      if (shift) begin
        mosi <= tx_head;
        tx_sr <= tx_next;
      end
    end
  end
endmodule

// File: tb/tb_spi_master_n.sv
// tb_spi_master_n: directed checks of spi_master_n in mode 0 (8-bit, 3 selects) and mode 3 (16-bit)
module tb_spi_master_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [1:0] sel_a = '0;
  logic sel_b = 1'b0;
  logic [7:0] tx_a = '0;
  logic [15:0] tx_b = '0;
  logic busy_a, done_a, sck_a, mosi_a, miso_a, busy_b, done_b, sck_b, mosi_b, miso_b;
  logic [7:0] rx_a;
  logic [15:0] rx_b;
  logic [2:0] csn_a;
  logic [0:0] csn_b;
  logic [6:0] bc_a, bc_b;
  logic [7:0] seq_a;
  logic [15:0] seq_b;
  logic [15:0] slv_b = 16'hBEEF;
  int edges_a = 0, edges_b = 0, nb = 0, nb0 = 0, dones_a = 0, cs_low = 0;
  int passes = 0, fails = 0, total = 0;

  spi_master_n #(.DATA_W(8), .NUM_CS(3), .CLK_DIV(2), .CPOL(0), .CPHA(0)) dut_a (
    .sclk_m(clk), .reset(rst_n), .start(start_a), .cs_sel(sel_a), .tx_data(tx_a),
    .busy(busy_a), .done(done_a), .rx_data(rx_a), .sck(sck_a), .cs_n(csn_a),
    .mosi(mosi_a), .miso(miso_a), .bit_cnt(bc_a));

  spi_master_n #(.DATA_W(16), .NUM_CS(1), .CLK_DIV(1), .CPOL(1), .CPHA(1)) dut_b (
    .sclk_m(clk), .reset(rst_n), .start(start_b), .cs_sel(sel_b), .tx_data(tx_b),
    .busy(busy_b), .done(done_b), .rx_data(rx_b), .sck(sck_b), .cs_n(csn_b),
    .mosi(mosi_b), .miso(miso_b), .bit_cnt(bc_b));

  always #5 clk = ~clk;
  assign miso_a = mosi_a;

  always @(sck_a) edges_a++;
  always @(sck_b) edges_b++;
  always @(posedge done_a) dones_a++;
  always @(csn_a) if (csn_a != 3'b111) cs_low++;
  always @(posedge sck_a) seq_a = {seq_a[6:0], mosi_a};
  always @(posedge sck_b) seq_b = {seq_b[14:0], mosi_b};
  always @(negedge sck_b) begin
`ifdef SPI_LSB_FIRST_EN
    miso_b = slv_b[nb - nb0];
`else
    miso_b = slv_b[15 - (nb - nb0)];
`endif
    nb++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit b, inout int cyc);
    while (!(b ? done_b : done_a) && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic go_a(input logic [7:0] tx, input logic [1:0] sel);
    tx_a = tx;
    sel_a = sel;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
  endtask

  initial begin
    int cyc, n, e0, c0, d0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_rx", rx_a, 0);
    chk("rst_sck_a", sck_a, 0);
    chk("rst_csn_a", csn_a, 3'b111);
    chk("rst_mosi", mosi_a, 0);
    chk("rst_bitcnt", bc_a, 0);
    chk("rst_sck_b", sck_b, 1);
    chk("rst_csn_b", csn_b, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    e0 = edges_a;
    go_a(8'hA5, 2'd2);
    cyc = 1;
    chk("m0_busy", busy_a, 1);
    chk("m0_csn", csn_a, 3'b011);
    chk("m0_first_mosi", mosi_a, 1);
    @(posedge clk);
    #1;
    cyc++;
    chk("m0_sck_c2", sck_a, 0);
    @(posedge clk);
    #1;
    cyc++;
    chk("m0_sck_c3", sck_a, 1);
    wait_done(0, cyc);
    chk("m0_done_cycle", cyc, 37);
    chk("m0_rx", rx_a, 8'hA5);
    chk("m0_mosi_serial", seq_a, 8'hA5);
    chk("m0_bitcnt", bc_a, 8);
    chk("m0_edges", edges_a - e0, 16);
    chk("m0_csn_done", csn_a, 3'b111);
    chk("m0_sck_idle", sck_a, 0);
    @(posedge clk);
    #1;
    chk("m0_done_width", done_a, 0);
    chk("m0_busy_fall", busy_a, 0);
    chk("m0_bitcnt_held", bc_a, 8);

    c0 = cs_low;
    go_a(8'h3C, 2'd3);
    cyc = 1;
    chk("oor_busy", busy_a, 1);
    chk("oor_csn", csn_a, 3'b111);
    wait_done(0, cyc);
    chk("oor_done_cycle", cyc, 37);
    chk("oor_rx", rx_a, 8'h3C);
    chk("oor_no_select", cs_low - c0, 0);
    @(posedge clk);
    #1;

    go_a(8'hFF, 2'd0);
    n = 0;
    while (bc_a != 7'd3 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_at_bit3", bc_a, 3);
    d0 = dones_a;
    rst_n = 1'b0;
    #1;
    chk("abort_csn", csn_a, 3'b111);
    chk("abort_sck", sck_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_bitcnt", bc_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_rx", rx_a, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_done", dones_a - d0, 0);
    chk("abort_idle", busy_a, 0);

    tx_a = 8'h5A;
    sel_a = 2'd1;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1;
    wait_done(0, cyc);
    chk("held_first_done", cyc, 37);
    n = 1;
    @(posedge clk);
    #1;
    chk("held_done_width", done_a, 0);
    chk("held_busy_fall", busy_a, 0);
    @(posedge clk);
    #1;
    n++;
    chk("held_restart", busy_a, 1);
    wait_done(0, n);
    start_a = 1'b0;
    chk("held_period", n, 38);
    chk("held_rx", rx_a, 8'h5A);
    repeat (3) @(posedge clk);
    #1;
    chk("held_idle", busy_a, 0);

    e0 = edges_b;
    nb0 = nb;
    tx_b = 16'h1234;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    cyc = 1;
    chk("m3_csn", csn_b, 0);
    chk("m3_sck_setup", sck_b, 1);
    wait_done(1, cyc);
    chk("m3_done_cycle", cyc, 35);
    chk("m3_rx", rx_b, 16'hBEEF);
`ifdef SPI_LSB_FIRST_EN
    chk("m3_mosi_serial", seq_b, 16'h2C48);
`else
    chk("m3_mosi_serial", seq_b, 16'h1234);
`endif
    chk("m3_edges", edges_b - e0, 32);
    chk("m3_bitcnt", bc_b, 16);
    chk("m3_sck_idle", sck_b, 1);
    @(posedge clk);
    #1;

    go_a(8'h01, 2'd0);
    cyc = 1;
`ifdef SPI_LSB_FIRST_EN
    chk("order_first_bit", mosi_a, 1);
`else
    chk("order_first_bit", mosi_a, 0);
`endif
    wait_done(0, cyc);
    chk("order_rx", rx_a, 8'h01);
    chk("order_done_cycle", cyc, 37);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
